time_of_day_counter: RTL
========================

Name: time_of_day_counter

Overview:
Free-running 24-hour timekeeper that feeds the clock-control FSM its live hours/minutes/seconds values.
- Derives a 1 Hz tick from the system clock via a prescaler.
- Advances the HH:MM:SS counters on each tick.
- Accepts a parallel load of user-set time when the FSM raises its update strobe.
- Emits minute and midnight pulses for the dose scheduler downstream.

Parameters:
CLK_HZ, 50000000, system clock cycles per second; prescaler terminal count is CLK_HZ-1
TICK_W, 26, prescaler counter width; must satisfy 2^TICK_W >= CLK_HZ

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low; clock is clock
update  input  1  load request from clock-control FSM; level, may stay high several cycles
hold  input  1  freeze timekeeping while user is setting time; active-high
loadHours  input  5  hours value to load, legal 0..23
loadMinutes  input  6  minutes value to load, legal 0..59
loadSeconds  input  6  seconds value to load, legal 0..59
hours  output  5  current hours 0..23
minutes  output  6  current minutes 0..59
seconds  output  6  current seconds 0..59
secTick  output  1  one-cycle pulse when seconds advances
minuteTick  output  1  one-cycle pulse when seconds wraps 59->0
dayRollover  output  1  one-cycle pulse when time wraps 23:59:59->00:00:00

Behaviour:
- Reset (reset==0 at clock edge):
  - hours, minutes, seconds, prescaler, update_d all set to 0.
  - secTick, minuteTick, dayRollover set to 0.
  - Reset overrides every other input.
- Load event: update==1 && update_d==0, where update_d is update registered one cycle.
  - A level held high loads exactly once.
  - On a load event, the next edge writes hours/minutes/seconds from the load ports.
  - Any out-of-range field (hours>23, minutes>59, seconds>59) is replaced by 0. Other fields load normally.
  - The prescaler clears to 0.
  - No tick pulses in that cycle.
- Priority, highest first: reset > load event > hold > normal counting. A load event during hold still loads.
- hold==1: prescaler and time registers frozen, all pulse outputs 0. On deassert, the prescaler resumes from its frozen value.
- Normal counting:
  - Prescaler increments each cycle.
  - At CLK_HZ-1 it wraps to 0 and the same edge asserts secTick for exactly one cycle. secTick is registered, coincident with the new seconds value.
- Seconds increments. 59->0 also increments minutes and asserts minuteTick in the same cycle as secTick.
- Minutes 59->0 increments hours.
- Hours 23->0 (i.e. 23:59:59->00:00:00) asserts dayRollover alongside secTick and minuteTick.
- Latency: the first secTick after a load or reset occurs CLK_HZ cycles after the load/reset edge.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package tod_pkg holds:
  - Width constants HOUR_W=5, MIN_W=6, SEC_W=6.
  - Limits MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59.
  - A time-of-day struct typedef {hours, minutes, seconds}, reused by the clock-control FSM and the time-set logic.
- One sub-module: tick_prescaler.
  - Parameters CLK_HZ and TICK_W.
  - Ports: clock, reset, clear, enable, tick.
  - Instantiated once for the 1 Hz strobe.
- Wrap/carry chain stays in the top module.

Test Plan:
All scenarios use CLK_HZ=4.
1. Reset held low 3 cycles, then released -> outputs 00:00:00, no pulses; first secTick on the 4th edge after release, seconds==1.
2. Load 23:59:58 via a single update pulse, run 8 cycles -> 23:59:59 after 4 cycles; 00:00:00 after 8 cycles with secTick, minuteTick and dayRollover high for that one cycle only.
3. update held high 10 cycles with loadMinutes changing mid-hold -> only the first-cycle values load; time then counts normally from the loaded value.
4. Load hours=25, minutes=30, seconds=61 -> hours=0, minutes=30, seconds=0.
5. hold=1 for 20 cycles mid-count at prescaler=2 -> time and prescaler unchanged, no pulses; after hold=0, secTick 2 cycles later.
6. reset=0 asserted in the same cycle as an update rising edge at 12:34:56 -> outputs 00:00:00; no load occurs after reset release until a new rising edge of update.

Source files
------------

// File: rtl/tod_pkg.sv
// tod_pkg: shared widths, limits and the time-of-day record used by the
// timekeeper, the clock-control FSM and the time-set logic.
//   HOUR_W/MIN_W/SEC_W : field widths
//   MAX_HOUR/MAX_MIN/MAX_SEC : last legal value of each field
//   tod_t : packed {hours, minutes, seconds}
//   sanitize_time() : zeroes any field outside its legal range
package tod_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
  } tod_t;

  // Each field is checked on its own so a single bad field does not
  // discard the good ones.
  function automatic tod_t sanitize_time(input tod_t raw);
    tod_t clean;
    clean.hours   = (raw.hours   > MAX_HOUR) ? '0 : raw.hours;
    clean.minutes = (raw.minutes > MAX_MIN)  ? '0 : raw.minutes;
    clean.seconds = (raw.seconds > MAX_SEC)  ? '0 : raw.seconds;
    return clean;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock down to a once-per-CLK_HZ strobe.
//   clock  : system clock, rising edge
//   reset  : synchronous, active-low
//   clear  : restart the count from 0 (wins over enable)
//   enable : count this cycle; when low the count is frozen
//   tick   : high in the cycle whose edge wraps the count to 0
// tick is deliberately combinational so the consumer can register its own
// outputs on the same edge the count wraps, keeping the first strobe exactly
// CLK_HZ cycles after reset/clear.
module tick_prescaler #(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_W = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [TICK_W-1:0] TERMINAL = TICK_W'(CLK_HZ - 1);

  logic [TICK_W-1:0] count;

  assign tick = enable && !clear && (count == TERMINAL);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: free-running 24-hour HH:MM:SS timekeeper.
//   clock       : system clock, rising edge
//   reset       : synchronous, active-low
//   update      : load request level; a rising edge loads once
//   hold        : freeze timekeeping while the user edits the time
//   loadHours/loadMinutes/loadSeconds : time to load (bad fields become 0)
//   hours/minutes/seconds : current time, registered
//   secTick     : one-cycle pulse with each new seconds value
//   minuteTick  : one-cycle pulse when seconds wraps 59->0
//   dayRollover : one-cycle pulse when 23:59:59 wraps to 00:00:00
module time_of_day_counter
  import tod_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_W = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              update,
  input  logic              hold,
  input  logic [HOUR_W-1:0] loadHours,
  input  logic [MIN_W-1:0]  loadMinutes,
  input  logic [SEC_W-1:0]  loadSeconds,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic              secTick,
  output logic              minuteTick,
  output logic              dayRollover
);

  tod_t time_q;
  tod_t advanced;
  tod_t load_value;
  logic update_d;
  logic load_event;
  logic sec_strobe;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;
  logic sec_tick_q;
  logic minute_tick_q;
  logic day_rollover_q;

  // Only the rising edge of update loads, so the FSM may hold it high.
  assign load_event = update && !update_d;

  assign load_value = '{hours: loadHours, minutes: loadMinutes, seconds: loadSeconds};

  // A load restarts the second so the first tick after it is a full second.
  tick_prescaler #(
    .CLK_HZ(CLK_HZ),
    .TICK_W(TICK_W)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (load_event),
    .enable(!hold),
    .tick  (sec_strobe)
  );

  assign sec_wrap  = (time_q.seconds == MAX_SEC);
  assign min_wrap  = (time_q.minutes == MAX_MIN);
  assign hour_wrap = (time_q.hours == MAX_HOUR);

  // Carry chain: seconds -> minutes -> hours.
  always_comb begin
    advanced = time_q;
    if (sec_wrap) begin
      advanced.seconds = '0;
      if (min_wrap) begin
        advanced.minutes = '0;
        advanced.hours   = hour_wrap ? '0 : time_q.hours + HOUR_W'(1);
      end else begin
        advanced.minutes = time_q.minutes + MIN_W'(1);
      end
    end else begin
      advanced.seconds = time_q.seconds + SEC_W'(1);
    end
  end

  // Pulses default low each cycle; a load suppresses them even if the
  // prescaler would otherwise have wrapped on this edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      time_q         <= '0;
      update_d       <= 1'b0;
      sec_tick_q     <= 1'b0;
      minute_tick_q  <= 1'b0;
      day_rollover_q <= 1'b0;
    end else begin
      update_d       <= update;
      sec_tick_q     <= 1'b0;
      minute_tick_q  <= 1'b0;
      day_rollover_q <= 1'b0;
      if (load_event) begin
        time_q <= sanitize_time(load_value);
      end else if (!hold && sec_strobe) begin
        time_q         <= advanced;
        sec_tick_q     <= 1'b1;
        minute_tick_q  <= sec_wrap;
        day_rollover_q <= sec_wrap && min_wrap && hour_wrap;
      end
    end
  end

  assign hours       = time_q.hours;
  assign minutes     = time_q.minutes;
  assign seconds     = time_q.seconds;
  assign secTick     = sec_tick_q;
  assign minuteTick  = minute_tick_q;
  assign dayRollover = day_rollover_q;

endmodule
